mul_unit: RTL and testbench



---
 rtl/mul_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for the RV32M mul/mulh/mulhsu/mulhu ops.
// Works on operand magnitudes, then fixes the sign of the 64-bit product.
// Optional build macro MUL_RADIX4_EN: consume two multiplier bits per CALC
// edge (16 iterations) instead of one (32 iterations).

package mul_pkg;
  typedef enum logic [2:0] {
    mulop_nop    = 3'd0,
    mulop_mul    = 3'd1,
    mulop_mulh   = 3'd2,
    mulop_mulhsu = 3'd3,
    mulop_mulhu  = 3'd4
  } rv32_mulop;
endpackage

module mul_unit
  import mul_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  rv32_mulop   i_mulop,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_e;

`ifdef MUL_RADIX4_EN
  localparam logic [5:0] N_ITER = 6'd16;
`else
  localparam logic [5:0] N_ITER = 6'd32;
`endif

  state_e      state_q, state_d;
  rv32_mulop   op_q, op_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
`ifdef MUL_RADIX4_EN
  logic [33:0] m3_q, m3_d;
  logic [33:0] addend;
  logic [33:0] sum;
`else
  logic [32:0] sum;
`endif

  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic [63:0] step_acc;
  logic [31:0] step_mplier;
  logic [63:0] prod;

  // Next-state: operand conditioning at accept, one shift-add step per CALC
  // edge, sign fix-up and half select in SIGN. Flush freezes everything but
  // the state, so a flushed request or result write never lands.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    s1   = ((i_mulop == mulop_mulh) || (i_mulop == mulop_mulhsu)) && i_rs1[31];
    s2   = (i_mulop == mulop_mulh) && i_rs2[31];
    mag1 = s1 ? (~i_rs1 + 32'd1) : i_rs1;
    mag2 = s2 ? (~i_rs2 + 32'd1) : i_rs2;
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;

    // Accumulator is kept right-aligned: add into the top half, then shift
    // the whole thing right by the number of multiplier bits consumed.
`ifdef MUL_RADIX4_EN
    m3_d = m3_q;
    case (mplier_q[1:0])
      2'd0:    addend = 34'd0;
      2'd1:    addend = {2'b00, mcand_q};
      2'd2:    addend = {1'b0, mcand_q, 1'b0};
      default: addend = m3_q;
    endcase
    sum         = {2'b00, acc_q[63:32]} + addend;
    step_acc    = {sum, acc_q[31:2]};
    step_mplier = {2'b00, mplier_q[31:2]};
`else
    sum         = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
    step_acc    = {sum, acc_q[31:1]};
    step_mplier = {1'b0, mplier_q[31:1]};
`endif

    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid && (i_mulop != mulop_nop)) begin
            op_d     = i_mulop;
            mcand_d  = mag1;
            mplier_d = mag2;
            neg_d    = s1 ^ s2;
            acc_d    = 64'd0;
            cnt_d    = N_ITER;
`ifdef MUL_RADIX4_EN
            m3_d     = {2'b00, mag1} + {1'b0, mag1, 1'b0};
`endif
            state_d  = S_CALC;
          end
        end
        S_CALC: begin
          acc_d    = step_acc;
          mplier_d = step_mplier;
          cnt_d    = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = S_SIGN;
        end
        S_SIGN: begin
          result_d = (op_q == mulop_mul) ? prod[31:0] : prod[63:32];
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears everything, including the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      op_q     <= mulop_nop;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
`ifdef MUL_RADIX4_EN
      m3_q     <= 34'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef MUL_RADIX4_EN
      m3_q     <= m3_d;
`endif
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Testbench for mul_unit: directed vectors, expected results queued at issue
// and popped by a monitor on each result handshake.
module tb_mul_unit;
  import mul_pkg::*;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid;
  rv32_mulop   i_mulop;
  logic [31:0] i_rs1, i_rs2, o_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  mul_unit dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mulop (i_mulop),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input rv32_mulop op, input logic [31:0] a, input logic [31:0] b);
    chk("ready_before_issue", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_mulop = op;
    i_rs1   = a;
    i_rs2   = b;
    tick;
    i_valid = 1'b0;
    i_mulop = mulop_nop;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic run(input rv32_mulop op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int n;
    sb.push_back(exp);
    issue(op, a, b);
    wait_valid(n);
    chk("latency", n, LAT);
    tick;
    chk("valid_one_cycle", {31'd0, o_valid}, 32'd0);
    chk("ready_after_done", {31'd0, o_ready}, 32'd1);
  endtask

  // Monitor: every result handshake must match the oldest queued expectation.
  always @(negedge i_clk) begin : monitor
    logic [31:0] e;
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%08h expected=none", o_result);
      end else begin
        e = sb.pop_front();
        chk("result", o_result, e);
      end
    end
  end

  initial begin
    int n;
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_mulop = mulop_nop; i_rs1 = '0; i_rs2 = '0;
    tick;
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    i_rst = 1'b0;
    tick;

    run(mulop_mul,    32'd7,        32'd6,        32'h0000002A);
    run(mulop_mulh,   32'h80000000, 32'h80000000, 32'h40000000);
    run(mulop_mulh,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);
    run(mulop_mulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(mulop_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(mulop_mul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run(mulop_mulh,   32'h80000000, 32'h7FFFFFFF, 32'hC0000000);

    // Backpressure in DONE
    i_ready = 1'b0;
    sb.push_back(32'h23456780);
    issue(mulop_mul, 32'h12345678, 32'h00000010);
    wait_valid(n);
    chk("bp_latency", n, LAT);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_result", o_result, 32'h23456780);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    tick;
    chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, o_valid}, 32'd0);

    // Flush at E5 of a mulhu; result register must be untouched
    issue(mulop_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) tick;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_result_kept", o_result, 32'h23456780);
    repeat (LAT + 3) tick;
    chk("flush_no_valid", {31'd0, o_valid}, 32'd0);
    run(mulop_mul, 32'd3, 32'd5, 32'h0000000F);

    // Flush in the same cycle as a request drops the request
    i_valid = 1'b1; i_mulop = mulop_mul; i_rs1 = 32'd2; i_rs2 = 32'd2;
    i_flush = 1'b1;
    tick;
    i_valid = 1'b0; i_flush = 1'b0; i_mulop = mulop_nop;
    chk("flush_beats_accept", {31'd0, o_ready}, 32'd1);

    // nop requests are ignored
    i_valid = 1'b1; i_mulop = mulop_nop; i_rs1 = 32'd9; i_rs2 = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("nop_ready", {31'd0, o_ready}, 32'd1);
    end
    i_valid = 1'b0;

    // Reset mid-CALC
    issue(mulop_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) tick;
    chk("calc_busy", {31'd0, o_ready}, 32'd0);
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid_result", o_result, 32'd0);
    chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    repeat (LAT + 3) tick;
    chk("rst_no_valid", {31'd0, o_valid}, 32'd0);
    run(mulop_mulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

    repeat (2) tick;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
